// File: rtl/rom_pkg.sv
// rtl/rom_pkg.sv - shared widths, entry formula and contents table for rom
package rom_pkg;

  localparam int ROM_ADDR_W = 5;
  localparam int ROM_DATA_W = 4;
  localparam int ROM_DEPTH  = 2 ** ROM_ADDR_W;

  typedef logic [ROM_DATA_W-1:0] rom_word_t;
  typedef logic [ROM_DEPTH-1:0][ROM_DATA_W-1:0] rom_table_t;

  // (3i+1) mod 2^DATA_W falls out of truncating to the word width
  function automatic rom_word_t rom_entry(input int i);
    return rom_word_t'(3 * i + 1);
  endfunction

  function automatic rom_table_t rom_build();
    rom_table_t t;
    for (int i = 0; i < ROM_DEPTH; i++) begin
      t[i] = rom_entry(i);
    end
    return t;
  endfunction

  localparam rom_table_t ROM_INIT = rom_build();

endpackage

// File: rtl/rom_array.sv
// rtl/rom_array.sv - combinational address-to-word lookup over the fixed table
module rom_array
  import rom_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] word
);

  logic [DATA_W-1:0] tbl [2**ADDR_W];

  // Default geometry shares the package table; other sizes apply the formula directly
  generate
    if (ADDR_W == ROM_ADDR_W && DATA_W == ROM_DATA_W) begin : g_pkg
      for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_entry
        assign tbl[i] = ROM_INIT[i];
      end
    end else begin : g_formula
      for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_entry
        assign tbl[i] = DATA_W'(3 * i + 1);
      end
    end
  endgenerate

  assign word = tbl[addr];

endmodule

// File: rtl/rom.sv
// rtl/rom.sv - registered 32x4 lookup ROM; ROM_OUT_REG_EN adds a second output stage
module rom
  import rom_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] rd_word;

  rom_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .addr(addr),
    .word(rd_word)
  );

`ifdef ROM_OUT_REG_EN
  logic [DATA_W-1:0] stage1_q;

  // Stage 1 follows the enable; stage 2 is a free-running retiming register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_q <= '0;
      data     <= '0;
    end else begin
      if (en) begin
        stage1_q <= rd_word;
      end
      data <= stage1_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (en) begin
      data <= rd_word;
    end
  end
`endif

endmodule

// File: tb/tb_rom.sv
// tb/tb_rom.sv - self-checking bench for rom against a behavioural read model
module tb_rom;
  import rom_pkg::*;

`ifdef ROM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                  clk;
  logic                  rst_n;
  logic                  en;
  logic [ROM_ADDR_W-1:0] addr;
  logic [ROM_DATA_W-1:0] data;

  int tests;
  int fails;
  bit cmp_on;

  logic [ROM_DATA_W-1:0] held;
  logic [ROM_DATA_W-1:0] late;
  logic [ROM_DATA_W-1:0] exp_data;

  int qa[$];
  int qe[$];

  rom dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .addr (addr),
    .data (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the last enabled read word, seen LAT edges after its address
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held <= '0;
      late <= '0;
    end else begin
      late <= held;
      if (en) held <= ROM_INIT[addr];
    end
  end

  assign exp_data = (LAT == 2) ? late : held;

  always @(negedge clk) begin
    if (cmp_on) begin
      tests++;
      if (data !== exp_data) begin
        fails++;
        $display("FAIL model_cmp t=%0t addr=%0d en=%0b got %0d expected %0d",
                 $time, addr, en, data, exp_data);
      end
    end
  end

  task automatic check(input string name, input logic [ROM_DATA_W-1:0] act,
                       input logic [ROM_DATA_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Streams qa with en=1 on successive edges and checks literal words in qe
  task automatic read_seq(input string name);
    int n;
    int j;
    n = qa.size();
    for (int k = 0; k < n + LAT - 1; k++) begin
      if (k < n) begin
        en   = 1'b1;
        addr = ROM_ADDR_W'(qa[k]);
      end else begin
        en = 1'b0;
      end
      @(negedge clk);
      j = k - (LAT - 1);
      if (j >= 0) check($sformatf("%s[%0d]", name, j), data, ROM_DATA_W'(qe[j]));
    end
    en = 1'b0;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    cmp_on = 1'b0;
    rst_n  = 1'b0;
    en     = 1'b1;
    addr   = 5'd5;

    #1 check("reset_immediate", data, 4'd0);
    repeat (2) begin
      @(negedge clk);
      check("reset_hold", data, 4'd0);
    end
    rst_n  = 1'b1;
    en     = 1'b0;
    cmp_on = 1'b1;

    qa = '{1, 2, 4, 5, 8};     qe = '{4, 7, 13, 0, 9};   read_seq("sweep1");
    qa = '{9, 10, 11, 12, 13}; qe = '{12, 15, 2, 5, 8};  read_seq("sweep2");
    qa = '{0, 31};             qe = '{1, 14};            read_seq("ends");

    qa = '{10}; qe = '{15}; read_seq("hold_load");
    en   = 1'b0;
    addr = 5'd3;
    repeat (3) begin
      @(negedge clk);
      check("hold_en0", data, 4'd15);
    end
    qa = '{3}; qe = '{10}; read_seq("reenable");

    qa = '{9}; qe = '{12}; read_seq("pre_reset");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", data, 4'd0);
    @(negedge clk);
    check("async_reset_held", data, 4'd0);
    rst_n = 1'b1;
    qa = '{2}; qe = '{7}; read_seq("post_reset");

    qa.delete();
    qe.delete();
    for (int i = 0; i < ROM_DEPTH; i++) begin
      qa.push_back(i);
      qe.push_back((3 * i + 1) % 16);
    end
    read_seq("exhaustive");

    for (int c = 0; c < 400; c++) begin
      en   = 1'($urandom_range(0, 3) != 0);
      addr = ROM_ADDR_W'($urandom);
      rst_n = ($urandom_range(0, 49) != 0);
      @(negedge clk);
      rst_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
